// File: rtl/memory_a_pkg.sv
// Shared sizing and types for the memory_a source buffer.
// Build option MEMORY_A_WRITE_THROUGH_EN (see memory_a.sv) does not affect this package.
package memory_a_pkg;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/memory_a_array.sv
// Raw storage for memory_a: per-word registers with async clear, one write
// port and a registered read port that only updates on read edges.
module memory_a_array
    import memory_a_pkg::*;
#(
    parameter int ADDR_W = memory_a_pkg::ADDR_W,
    parameter int DATA_W = memory_a_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int WORDS = 2 ** ADDR_W;

    logic [DATA_W-1:0] word_arr [WORDS];
    logic [DATA_W-1:0] rdata_q;

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            logic [DATA_W-1:0] word_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    word_q <= '0;
                end else if (we_i && addr_i == ADDR_W'(gi)) begin
                    word_q <= wdata_i;
                end
            end

            assign word_arr[gi] = word_q;
        end
    endgenerate

    // Explicit compare against 0 so an unknown enable neither writes nor reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (we_i == 1'b0) begin
            rdata_q <= word_arr[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/memory_a.sv
// 8x8 single-port source buffer feeding the downstream memory via DOut1.
// Define MEMORY_A_WRITE_THROUGH_EN to present write data on DOut1 after a write edge.
module memory_a
    import memory_a_pkg::*;
#(
    parameter int ADDR_W = memory_a_pkg::ADDR_W,
    parameter int DATA_W = memory_a_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic              WEA,
    input  logic [DATA_W-1:0] DataInA,
    output logic [DATA_W-1:0] DOut1
);
    logic [DATA_W-1:0] rd_data;

    memory_a_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .we_i    (WEA),
        .addr_i  (AddrA),
        .wdata_i (DataInA),
        .rdata_o (rd_data)
    );

`ifdef MEMORY_A_WRITE_THROUGH_EN
    // Last edge was a write: show the bypassed data until the next read edge.
    logic              byp_sel_q;
    logic [DATA_W-1:0] byp_data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byp_sel_q  <= 1'b0;
            byp_data_q <= '0;
        end else if (WEA == 1'b1) begin
            byp_sel_q  <= 1'b1;
            byp_data_q <= DataInA;
        end else if (WEA == 1'b0) begin
            byp_sel_q  <= 1'b0;
        end
    end

    assign DOut1 = byp_sel_q ? byp_data_q : rd_data;
`else
    assign DOut1 = rd_data;
`endif
endmodule

// File: tb/tb_memory_a.sv
// Self-checking bench for memory_a: directed plan plus randomized traffic
// compared against an array-based reference of the buffer.
module tb_memory_a;
    import memory_a_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  AddrA = '0;
    logic        WEA = 1'b0;
    logic [7:0]  DataInA = '0;
    logic [7:0]  DOut1;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [7:0] ref_mem [8];
    logic [7:0] ref_dout;
    logic [7:0] fill_tbl [8];

    memory_a dut (
        .clock   (clock),
        .reset   (reset),
        .AddrA   (AddrA),
        .WEA     (WEA),
        .DataInA (DataInA),
        .DOut1   (DOut1)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
        ref_dout = 8'h00;
    endtask

    // One clock edge; the reference is updated from the buffer's rules, then compared.
    task automatic op(input string tag, input logic we, input logic [2:0] a, input logic [7:0] d);
        WEA = we; AddrA = a; DataInA = d;
        @(posedge clock);
        #1;
        if (we) begin
            ref_mem[a] = d;
`ifdef MEMORY_A_WRITE_THROUGH_EN
            ref_dout = d;
`endif
        end else begin
            ref_dout = ref_mem[a];
        end
        check(tag, DOut1, ref_dout);
        $display("op %-6s we=%0d addr=%0d din=%02h dout=%02h", tag, we, a, d, DOut1);
    endtask

    // Reset asserted away from the edge; output must clear without a clock.
    task automatic pulse_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check(tag, DOut1, 8'h00);
        @(posedge clock);
        #1;
        check({tag, "_hold"}, DOut1, 8'h00);
        reset = 1'b0;
    endtask

    initial begin
        fill_tbl[0] = 8'hFF; fill_tbl[1] = 8'h00; fill_tbl[2] = 8'h02; fill_tbl[3] = 8'h04;
        fill_tbl[4] = 8'h08; fill_tbl[5] = 8'h10; fill_tbl[6] = 8'h20; fill_tbl[7] = 8'h40;
        model_clear();

        repeat (2) @(posedge clock);
        #1;
        check("rst", DOut1, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            op("fill", 1'b1, 3'(i), fill_tbl[i]);
`ifndef MEMORY_A_WRITE_THROUGH_EN
            check("fill0", DOut1, 8'h00);
`endif
        end

        for (int i = 0; i < 8; i++) begin
            op("rdbk", 1'b0, 3'(i), 8'h00);
            check("rdtbl", DOut1, fill_tbl[i]);
        end

        op("ow1", 1'b1, 3'd5, 8'hA5);
        op("ow2", 1'b1, 3'd5, 8'h5A);
        op("rd5", 1'b0, 3'd5, 8'h00);
        check("ow5", DOut1, 8'h5A);
        op("rd4", 1'b0, 3'd4, 8'h00);
        check("ow4", DOut1, 8'h08);
        op("rd6", 1'b0, 3'd6, 8'h00);
        check("ow6", DOut1, 8'h20);

        op("rd0", 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            op("idle", 1'b0, 3'd0, 8'h77);
            check("hold", DOut1, 8'hFF);
        end
        op("wr1", 1'b1, 3'd1, 8'h99);
`ifndef MEMORY_A_WRITE_THROUGH_EN
        check("wrhold", DOut1, 8'hFF);
`endif

        pulse_reset("rstmid");
        op("rd3", 1'b0, 3'd3, 8'h00);
        check("rst3", DOut1, 8'h00);
        op("rd0z", 1'b0, 3'd0, 8'h00);
        check("rst0", DOut1, 8'h00);

`ifdef MEMORY_A_WRITE_THROUGH_EN
        op("wt", 1'b1, 3'd2, 8'h3C);
        check("wtbyp", DOut1, 8'h3C);
        op("wtrd", 1'b0, 3'd2, 8'h00);
        check("wtrd2", DOut1, 8'h3C);
`endif

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                pulse_reset("rrst");
            end else begin
                op("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
            end
        end

        for (int i = 0; i < 8; i++) op("final", 1'b0, 3'(i), 8'h00);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d checks expected completion", chk_cnt);
        $fatal(1);
    end
endmodule
